// File: rtl/hazard_forwarding_unit_if.sv
// Signal bundle between the ID stage / control unit and the hazard/forwarding controller.
// The hazard unit sits on the slave side; the datapath (or a bench) drives the master side.
interface hazard_forwarding_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] ID_rs1;
    logic [REG_AW-1:0] ID_rs2;
    logic              ID_use_rs1;
    logic              ID_use_rs2;
    logic [REG_AW-1:0] ID_rd;
    logic              ID_RF_Enable;
    logic              ID_Load_Instr;
    logic              EX_branch_taken;
    logic              MEM_wait;

    logic              CU_mux_sel;
    logic              PC_LE;
    logic              IF_ID_LE;
    logic              IF_ID_flush;
    logic              PIPE_LE;
    logic [1:0]        FWD_A_sel;
    logic [1:0]        FWD_B_sel;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd,
               ID_RF_Enable, ID_Load_Instr, EX_branch_taken, MEM_wait,
        input  CU_mux_sel, PC_LE, IF_ID_LE, IF_ID_flush, PIPE_LE,
               FWD_A_sel, FWD_B_sel, stall_cnt
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_rd,
               ID_RF_Enable, ID_Load_Instr, EX_branch_taken, MEM_wait,
        output CU_mux_sel, PC_LE, IF_ID_LE, IF_ID_flush, PIPE_LE,
               FWD_A_sel, FWD_B_sel, stall_cnt
    );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: operand forwarding selects, load-use
// bubbles, branch squash, memory-wait freeze and a saturating stall-cycle counter.
module hazard_forwarding_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic                    clk,
    input logic                    reset,
    hazard_forwarding_unit_if.slave hz
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              rf_en;
        logic              load;
    } slot_t;

    typedef enum logic {
        RUN,
        MEM_HOLD
    } state_t;

    slot_t            ex_q, mem_q, wb_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic             cu_mux_sel;
    logic             pc_le;
    logic             if_id_le;
    logic             if_id_flush;
    logic             pipe_le;
    logic             load_use;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    // x0 is hardwired zero, so a write to it is never a producer.
    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.rf_en & (s.rd == r) & (r != '0);
    endfunction

    function automatic logic [1:0] fwd_select(input slot_t ex, input slot_t mem,
                                              input slot_t wb, input logic [REG_AW-1:0] r);
        if (slot_match(ex, r))
            return 2'b01;
        else if (slot_match(mem, r))
            return 2'b10;
        else if (slot_match(wb, r))
            return 2'b11;
        else
            return 2'b00;
    endfunction

    always_comb begin
        fwd_a    = fwd_select(ex_q, mem_q, wb_q, hz.ID_rs1);
        fwd_b    = fwd_select(ex_q, mem_q, wb_q, hz.ID_rs2);
        load_use = ex_q.load &
                   ((hz.ID_use_rs1 & slot_match(ex_q, hz.ID_rs1)) |
                    (hz.ID_use_rs2 & slot_match(ex_q, hz.ID_rs2)));
    end

    // A memory wait freezes everything; otherwise a taken branch outranks a load-use bubble.
    always_comb begin
        state_d     = state_q;
        cu_mux_sel  = 1'b0;
        pc_le       = 1'b1;
        if_id_le    = 1'b1;
        if_id_flush = 1'b0;
        pipe_le     = 1'b1;

        unique case (state_q)
            RUN, MEM_HOLD: begin
                if (hz.MEM_wait) begin
                    state_d  = MEM_HOLD;
                    pc_le    = 1'b0;
                    if_id_le = 1'b0;
                    pipe_le  = 1'b0;
                end else begin
                    state_d = RUN;
                    if (hz.EX_branch_taken) begin
                        if_id_flush = 1'b1;
                        cu_mux_sel  = 1'b1;
                    end else if (load_use) begin
                        cu_mux_sel = 1'b1;
                        pc_le      = 1'b0;
                        if_id_le   = 1'b0;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // The shadow copy of EX/MEM/WB only moves when the real pipeline registers load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (pipe_le) begin
            ex_q  <= '{valid: ~cu_mux_sel, rd: hz.ID_rd,
                       rf_en: hz.ID_RF_Enable, load: hz.ID_Load_Instr};
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if ((cu_mux_sel | hz.MEM_wait) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign hz.CU_mux_sel  = cu_mux_sel;
    assign hz.PC_LE       = pc_le;
    assign hz.IF_ID_LE    = if_id_le;
    assign hz.IF_ID_flush = if_id_flush;
    assign hz.PIPE_LE     = pipe_le;
    assign hz.FWD_A_sel   = fwd_a;
    assign hz.FWD_B_sel   = fwd_b;
    assign hz.stall_cnt   = cnt_q;

endmodule
